// File: rtl/fetch_unit_if.sv
// Bus between the fetch stage and its surroundings: instruction memory port,
// pipeline control from decode and the IF/ID register contents.
interface fetch_unit_if;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        flush;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        ifid_valid;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_pc_plus4;
  logic        halted;

  modport master (
    input  stall, redirect_valid, redirect_target, flush, imem_instr,
    output imem_addr, ifid_valid, ifid_instr, ifid_pc, ifid_pc_plus4, halted
  );

  modport slave (
    output stall, redirect_valid, redirect_target, flush, imem_instr,
    input  imem_addr, ifid_valid, ifid_instr, ifid_pc, ifid_pc_plus4, halted
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches from combinational imem into IF/ID.
// Optional macro BRANCH_DELAY_SLOT_EN keeps the slot after a taken redirect instead of squashing it.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0180,
  parameter logic [31:0] HALT_WORD  = 32'hFFFF_FFFF
) (
  input  logic       clk,
  input  logic       reset,
  fetch_unit_if.master bus
);

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] ipc_q, ipc_d;
  logic [31:0] ipc4_q, ipc4_d;
  logic        halted_q, halted_d;

  logic [31:0] pc_plus4_s;
  logic [31:0] target_s;
  logic [31:0] exc_pc_s;
  logic        is_halt_s;

  assign pc_plus4_s = pc_q + 32'd4;
  assign target_s   = {bus.redirect_target[31:2], 2'b00};
  assign exc_pc_s   = {EXC_VECTOR[31:2], 2'b00};
  assign is_halt_s  = (bus.imem_instr == HALT_WORD);

  // Next-state: flush beats stall beats redirect beats sequential fetch.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    valid_d  = valid_q;
    instr_d  = instr_q;
    ipc_d    = ipc_q;
    ipc4_d   = ipc4_q;
    halted_d = halted_q;
    case (state_q)
      ST_RUN: begin
        halted_d = 1'b0;
        if (bus.flush) begin
          pc_d    = exc_pc_s;
          valid_d = 1'b0;
          instr_d = 32'h0000_0000;
        end else if (bus.stall) begin
          state_d = ST_RUN;
        end else begin
          ipc_d  = pc_q;
          ipc4_d = pc_plus4_s;
`ifdef BRANCH_DELAY_SLOT_EN
          instr_d = bus.imem_instr;
          valid_d = 1'b1;
          if (is_halt_s) begin
            state_d = ST_HALT;
          end else if (bus.redirect_valid) begin
            pc_d = target_s;
          end else begin
            pc_d = pc_plus4_s;
          end
`else
          // A squashed slot never reaches decode, so it cannot halt either.
          if (bus.redirect_valid) begin
            valid_d = 1'b0;
            instr_d = 32'h0000_0000;
            pc_d    = target_s;
          end else begin
            instr_d = bus.imem_instr;
            valid_d = 1'b1;
            if (is_halt_s) begin
              state_d = ST_HALT;
            end else begin
              pc_d = pc_plus4_s;
            end
          end
`endif
        end
      end
      ST_HALT: begin
        halted_d = 1'b1;
        if (bus.flush) begin
          pc_d     = exc_pc_s;
          valid_d  = 1'b0;
          instr_d  = 32'h0000_0000;
          halted_d = 1'b0;
          state_d  = ST_RUN;
        end else if (bus.stall) begin
          state_d = ST_HALT;
        end else begin
          valid_d = 1'b0;
          instr_d = 32'h0000_0000;
        end
      end
      default: begin
        state_d  = ST_RUN;
        pc_d     = RESET_PC;
        valid_d  = 1'b0;
        instr_d  = 32'h0000_0000;
        halted_d = 1'b0;
      end
    endcase
  end

  // State and IF/ID register update with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_RUN;
      pc_q     <= RESET_PC;
      valid_q  <= 1'b0;
      instr_q  <= 32'h0000_0000;
      ipc_q    <= 32'h0000_0000;
      ipc4_q   <= 32'h0000_0000;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      valid_q  <= valid_d;
      instr_q  <= instr_d;
      ipc_q    <= ipc_d;
      ipc4_q   <= ipc4_d;
      halted_q <= halted_d;
    end
  end

  assign bus.imem_addr     = pc_q;
  assign bus.ifid_valid    = valid_q;
  assign bus.ifid_instr    = instr_q;
  assign bus.ifid_pc       = ipc_q;
  assign bus.ifid_pc_plus4 = ipc4_q;
  assign bus.halted        = halted_q;

endmodule
